fetch_dreg: RTL and testbench

- Fetch stage of the five-stage pipelined Y86-64 processor, plus the F and D pipeline registers.
- Selects the fetch PC and presents it to instruction memory.
- Splits the 10 returned bytes into instruction fields and computes valP and the predicted next PC.
- Latches the fields into the D register consumed by decode/writeback: D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat.

---
 rtl/fetch_dreg_if.sv | 19 +
 rtl/fetch_dreg.sv | 188 ++++++++++++++++++
 tb/tb_fetch_dreg.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_dreg_if.sv
// Instruction-memory port of the Y86-64 fetch stage: fetch address out, 10 raw bytes and an error flag back.
// Purely combinational; memory answers in the same cycle the address is presented.
interface fetch_dreg_if;
    logic [63:0] imem_addr;
    logic [79:0] imem_rdata;
    logic        imem_error;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  imem_error
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output imem_error
    );
endinterface

// File: rtl/fetch_dreg.sv
// Y86-64 fetch stage with the F (predicted PC) and D pipeline registers.
// Latency: fields reach D_* one cycle after f_pc is presented; F_stall/D_stall hold, D_bubble injects a nop.
module fetch_dreg #(
    parameter logic [63:0] PC_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    fetch_dreg_if.master imem,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic [2:0]  D_stat,
    output logic [63:0] F_predPC
);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] R_NONE  = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    logic [63:0] r_predpc;
    logic [3:0]  r_icode;
    logic [3:0]  r_ifun;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [63:0] r_valc;
    logic [63:0] r_valp;
    logic [2:0]  r_stat;

    logic [63:0] w_f_pc;
    logic [7:0]  w_byte0;
    logic [7:0]  w_byte1;
    logic [3:0]  w_icode;
    logic [3:0]  w_ifun;
    logic        w_instr_valid;
    logic        w_need_regids;
    logic        w_need_valc;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [63:0] w_valc;
    logic [63:0] w_valp;
    logic [63:0] w_f_predpc;
    logic [2:0]  w_stat;

    // A mispredicted branch resolving in M outranks a ret completing in W.
    always_comb begin
        w_f_pc = r_predpc;
        if (M_icode == I_JXX && !M_Cnd) begin
            w_f_pc = M_valA;
        end else if (W_icode == I_RET) begin
            w_f_pc = W_valM;
        end
    end

    assign imem.imem_addr = w_f_pc;

    assign w_byte0 = imem.imem_rdata[7:0];
    assign w_byte1 = imem.imem_rdata[15:8];

    always_comb begin
        w_icode = w_byte0[7:4];
        w_ifun  = w_byte0[3:0];
        if (imem.imem_error) begin
            w_icode = I_NOP;
            w_ifun  = 4'h0;
        end
    end

    assign w_instr_valid = (w_icode <= 4'hB);

    always_comb begin
        w_need_regids = 1'b0;
        w_need_valc   = 1'b0;
        case (w_icode)
            4'h2, 4'h6, 4'hA, 4'hB: w_need_regids = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                w_need_regids = 1'b1;
                w_need_valc   = 1'b1;
            end
            4'h7, 4'h8:             w_need_valc   = 1'b1;
            default: begin
                w_need_regids = 1'b0;
                w_need_valc   = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_ra = R_NONE;
        w_rb = R_NONE;
        if (w_need_regids) begin
            w_ra = w_byte1[7:4];
            w_rb = w_byte1[3:0];
        end
    end

    // The constant word sits right after the register byte when there is one.
    always_comb begin
        w_valc = 64'h0;
        if (w_need_valc) begin
            w_valc = w_need_regids ? imem.imem_rdata[79:16] : imem.imem_rdata[71:8];
        end
    end

    assign w_valp = w_f_pc + 64'd1
                  + {63'h0, w_need_regids}
                  + (w_need_valc ? 64'd8 : 64'd0);

    assign w_f_predpc = (w_icode == I_JXX || w_icode == I_CALL) ? w_valc : w_valp;

    always_comb begin
        w_stat = S_AOK;
        if (imem.imem_error) begin
            w_stat = S_ADR;
        end else if (!w_instr_valid) begin
            w_stat = S_INS;
        end else if (w_icode == I_HALT) begin
            w_stat = S_HLT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_predpc <= PC_RESET;
        end else if (!F_stall) begin
            r_predpc <= w_f_predpc;
        end
    end

    // Stall takes precedence over bubble; reset overrides both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_icode <= I_NOP;
            r_ifun  <= 4'h0;
            r_ra    <= R_NONE;
            r_rb    <= R_NONE;
            r_valc  <= 64'h0;
            r_valp  <= 64'h0;
            r_stat  <= S_AOK;
        end else if (!D_stall) begin
            if (D_bubble) begin
                r_icode <= I_NOP;
                r_ifun  <= 4'h0;
                r_ra    <= R_NONE;
                r_rb    <= R_NONE;
                r_valc  <= 64'h0;
                r_valp  <= 64'h0;
                r_stat  <= S_AOK;
            end else begin
                r_icode <= w_icode;
                r_ifun  <= w_ifun;
                r_ra    <= w_ra;
                r_rb    <= w_rb;
                r_valc  <= w_valc;
                r_valp  <= w_valp;
                r_stat  <= w_stat;
            end
        end
    end

    assign F_predPC = r_predpc;
    assign D_icode  = r_icode;
    assign D_ifun   = r_ifun;
    assign D_rA     = r_ra;
    assign D_rB     = r_rb;
    assign D_valC   = r_valc;
    assign D_valP   = r_valp;
    assign D_stat   = r_stat;

endmodule

// File: tb/tb_fetch_dreg.sv
// Directed bench for fetch_dreg: hand-computed Y86-64 fetch/decode vectors driven straight onto the imem port.
module tb_fetch_dreg;

    localparam logic [79:0] IRMOV = 80'h0000_0000_0000_0100_F030; // irmovq $0x100,%rax
    localparam logic [79:0] JMP40 = 80'h0000_0000_0000_0000_4070; // jmp 0x40
    localparam logic [79:0] RRMOV = 80'h0000_0000_0000_0000_1220; // rrmovq %rcx,%rdx
    localparam logic [79:0] CALL2 = 80'h0000_0000_0000_0002_0080; // call 0x200

    logic        clk = 1'b0;
    logic        rst_n;
    logic        F_stall, D_stall, D_bubble;
    logic [3:0]  M_icode, W_icode;
    logic        M_Cnd;
    logic [63:0] M_valA, W_valM;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP, F_predPC;
    logic [2:0]  D_stat;

    int n_cmp = 0;
    int n_err = 0;

    fetch_dreg_if imem_bus ();

    fetch_dreg #(.PC_RESET(64'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .F_stall  (F_stall),
        .D_stall  (D_stall),
        .D_bubble (D_bubble),
        .M_icode  (M_icode),
        .M_Cnd    (M_Cnd),
        .M_valA   (M_valA),
        .W_icode  (W_icode),
        .W_valM   (W_valM),
        .imem     (imem_bus.master),
        .D_icode  (D_icode),
        .D_ifun   (D_ifun),
        .D_rA     (D_rA),
        .D_rB     (D_rB),
        .D_valC   (D_valC),
        .D_valP   (D_valP),
        .D_stat   (D_stat),
        .F_predPC (F_predPC)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        M_icode = 4'h1; M_Cnd = 1'b0; M_valA = 64'h0;
        W_icode = 4'h1; W_valM = 64'h0;
        imem_bus.imem_rdata = 80'h0; imem_bus.imem_error = 1'b0;
        tick(); tick();
        n_cmp++; if (F_predPC !== 64'h0) begin n_err++; $display("FAIL reset_predpc got %h want %h", F_predPC, 64'h0); end
        n_cmp++; if (D_icode !== 4'h1) begin n_err++; $display("FAIL reset_icode got %h want %h", D_icode, 4'h1); end
        n_cmp++; if (D_ifun !== 4'h0) begin n_err++; $display("FAIL reset_ifun got %h want %h", D_ifun, 4'h0); end
        n_cmp++; if (D_rA !== 4'hF || D_rB !== 4'hF) begin n_err++; $display("FAIL reset_regs got %h/%h want F/F", D_rA, D_rB); end
        n_cmp++; if (D_valC !== 64'h0 || D_valP !== 64'h0) begin n_err++; $display("FAIL reset_vals got %h/%h want 0/0", D_valC, D_valP); end
        n_cmp++; if (D_stat !== 3'd1) begin n_err++; $display("FAIL reset_stat got %0d want 1", D_stat); end
    endtask

    task automatic test_irmovq(input string tag);
        imem_bus.imem_rdata = IRMOV;
        #1;
        n_cmp++; if (imem_bus.imem_addr !== 64'h0) begin n_err++; $display("FAIL %s_addr got %h want 0", tag, imem_bus.imem_addr); end
        tick();
        n_cmp++; if (D_icode !== 4'h3 || D_ifun !== 4'h0) begin n_err++; $display("FAIL %s_icode got %h/%h want 3/0", tag, D_icode, D_ifun); end
        n_cmp++; if (D_rA !== 4'hF || D_rB !== 4'h0) begin n_err++; $display("FAIL %s_regs got %h/%h want F/0", tag, D_rA, D_rB); end
        n_cmp++; if (D_valC !== 64'h100) begin n_err++; $display("FAIL %s_valc got %h want 100", tag, D_valC); end
        n_cmp++; if (D_valP !== 64'hA) begin n_err++; $display("FAIL %s_valp got %h want a", tag, D_valP); end
        n_cmp++; if (D_stat !== 3'd1) begin n_err++; $display("FAIL %s_stat got %0d want 1", tag, D_stat); end
        n_cmp++; if (F_predPC !== 64'hA) begin n_err++; $display("FAIL %s_predpc got %h want a", tag, F_predPC); end
    endtask

    task automatic test_jmp();
        imem_bus.imem_rdata = JMP40;
        #1;
        n_cmp++; if (imem_bus.imem_addr !== 64'hA) begin n_err++; $display("FAIL jmp_addr got %h want a", imem_bus.imem_addr); end
        tick();
        n_cmp++; if (F_predPC !== 64'h40) begin n_err++; $display("FAIL jmp_predpc got %h want 40", F_predPC); end
        n_cmp++; if (D_valC !== 64'h40) begin n_err++; $display("FAIL jmp_valc got %h want 40", D_valC); end
        n_cmp++; if (D_valP !== 64'h13) begin n_err++; $display("FAIL jmp_valp got %h want 13", D_valP); end
        n_cmp++; if (D_rA !== 4'hF || D_rB !== 4'hF) begin n_err++; $display("FAIL jmp_regs got %h/%h want F/F", D_rA, D_rB); end
        n_cmp++; if (D_icode !== 4'h7) begin n_err++; $display("FAIL jmp_icode got %h want 7", D_icode); end
    endtask

    task automatic test_redirect();
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h55; W_icode = 4'h9; W_valM = 64'h99;
        #1;
        n_cmp++; if (imem_bus.imem_addr !== 64'h55) begin n_err++; $display("FAIL redir_mispredict got %h want 55", imem_bus.imem_addr); end
        M_Cnd = 1'b1;
        #1;
        n_cmp++; if (imem_bus.imem_addr !== 64'h99) begin n_err++; $display("FAIL redir_ret got %h want 99", imem_bus.imem_addr); end
        W_icode = 4'h1;
        #1;
        n_cmp++; if (imem_bus.imem_addr !== 64'h40) begin n_err++; $display("FAIL redir_pred got %h want 40", imem_bus.imem_addr); end
        M_icode = 4'h1; M_Cnd = 1'b0;
    endtask

    task automatic test_stall();
        imem_bus.imem_rdata = IRMOV;
        F_stall = 1'b1; D_stall = 1'b1;
        tick(); tick();
        n_cmp++; if (F_predPC !== 64'h40) begin n_err++; $display("FAIL stall_predpc got %h want 40", F_predPC); end
        n_cmp++; if (D_icode !== 4'h7 || D_valC !== 64'h40 || D_valP !== 64'h13 || D_rA !== 4'hF)
            begin n_err++; $display("FAIL stall_dreg got %h/%h/%h/%h want 7/40/13/F", D_icode, D_valC, D_valP, D_rA); end
        F_stall = 1'b0; D_stall = 1'b0;
    endtask

    task automatic test_bubble();
        F_stall = 1'b1; D_bubble = 1'b1;
        tick();
        n_cmp++; if (D_icode !== 4'h1 || D_rA !== 4'hF || D_rB !== 4'hF) begin n_err++; $display("FAIL bubble_fields got %h/%h/%h want 1/F/F", D_icode, D_rA, D_rB); end
        n_cmp++; if (D_stat !== 3'd1 || D_valP !== 64'h0 || D_valC !== 64'h0) begin n_err++; $display("FAIL bubble_vals got %0d/%h/%h want 1/0/0", D_stat, D_valP, D_valC); end
        F_stall = 1'b0; D_bubble = 1'b0;
        tick();
        n_cmp++; if (D_icode !== 4'h3 || D_valP !== 64'h4A || F_predPC !== 64'h4A) begin n_err++; $display("FAIL bubble_reload got %h/%h/%h want 3/4a/4a", D_icode, D_valP, F_predPC); end
        F_stall = 1'b1; D_stall = 1'b1; D_bubble = 1'b1; imem_bus.imem_rdata = JMP40;
        tick();
        n_cmp++; if (D_icode !== 4'h3 || D_valP !== 64'h4A || D_valC !== 64'h100) begin n_err++; $display("FAIL stall_over_bubble got %h/%h/%h want 3/4a/100", D_icode, D_valP, D_valC); end
        D_stall = 1'b0; D_bubble = 1'b0;
    endtask

    task automatic test_status();
        imem_bus.imem_rdata = 80'hC0;
        tick();
        n_cmp++; if (D_icode !== 4'hC || D_stat !== 3'd4) begin n_err++; $display("FAIL stat_ins got %h/%0d want C/4", D_icode, D_stat); end
        n_cmp++; if (D_valP !== 64'h4B || D_rA !== 4'hF) begin n_err++; $display("FAIL stat_ins_valp got %h/%h want 4b/F", D_valP, D_rA); end
        imem_bus.imem_rdata = 80'h00;
        tick();
        n_cmp++; if (D_icode !== 4'h0 || D_stat !== 3'd2) begin n_err++; $display("FAIL stat_hlt got %h/%0d want 0/2", D_icode, D_stat); end
        imem_bus.imem_rdata = 80'hC0; imem_bus.imem_error = 1'b1;
        tick();
        n_cmp++; if (D_icode !== 4'h1 || D_ifun !== 4'h0 || D_stat !== 3'd3) begin n_err++; $display("FAIL stat_adr got %h/%h/%0d want 1/0/3", D_icode, D_ifun, D_stat); end
        n_cmp++; if (D_valP !== 64'h4B) begin n_err++; $display("FAIL stat_adr_valp got %h want 4b", D_valP); end
        imem_bus.imem_error = 1'b0; F_stall = 1'b0;
    endtask

    task automatic test_fields();
        imem_bus.imem_rdata = RRMOV;
        tick();
        n_cmp++; if (D_icode !== 4'h2 || D_rA !== 4'h1 || D_rB !== 4'h2) begin n_err++; $display("FAIL rrmov_fields got %h/%h/%h want 2/1/2", D_icode, D_rA, D_rB); end
        n_cmp++; if (D_valC !== 64'h0 || D_valP !== 64'h4C || F_predPC !== 64'h4C) begin n_err++; $display("FAIL rrmov_vals got %h/%h/%h want 0/4c/4c", D_valC, D_valP, F_predPC); end
        imem_bus.imem_rdata = CALL2;
        tick();
        n_cmp++; if (D_icode !== 4'h8 || D_valC !== 64'h200 || D_rA !== 4'hF) begin n_err++; $display("FAIL call_fields got %h/%h/%h want 8/200/F", D_icode, D_valC, D_rA); end
        n_cmp++; if (D_valP !== 64'h55 || F_predPC !== 64'h200) begin n_err++; $display("FAIL call_pc got %h/%h want 55/200", D_valP, F_predPC); end
    endtask

    task automatic test_wrap();
        W_icode = 4'h9; W_valM = 64'hFFFF_FFFF_FFFF_FFFC; imem_bus.imem_rdata = IRMOV;
        tick();
        n_cmp++; if (D_valP !== 64'h6 || F_predPC !== 64'h6 || D_valC !== 64'h100) begin n_err++; $display("FAIL wrap_valp got %h/%h/%h want 6/6/100", D_valP, F_predPC, D_valC); end
        W_icode = 4'h1;
    endtask

    task automatic test_reset_mid();
        imem_bus.imem_rdata = RRMOV;
        tick(); tick(); tick();
        n_cmp++; if (F_predPC !== 64'hC || D_valP !== 64'hC) begin n_err++; $display("FAIL mid_stream got %h/%h want c/c", F_predPC, D_valP); end
        rst_n = 1'b0; F_stall = 1'b1;
        tick();
        n_cmp++; if (F_predPC !== 64'h0) begin n_err++; $display("FAIL mid_reset_pc got %h want 0", F_predPC); end
        n_cmp++; if (D_icode !== 4'h1 || D_rA !== 4'hF || D_rB !== 4'hF || D_valP !== 64'h0 || D_stat !== 3'd1)
            begin n_err++; $display("FAIL mid_reset_dreg got %h/%h/%h/%h/%0d want 1/F/F/0/1", D_icode, D_rA, D_rB, D_valP, D_stat); end
        rst_n = 1'b1; F_stall = 1'b0;
        test_irmovq("refetch");
    endtask

    initial begin
        test_reset();
        rst_n = 1'b1;
        test_irmovq("irmov");
        test_jmp();
        test_redirect();
        test_stall();
        test_bubble();
        test_status();
        test_fields();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
